// File: rtl/eco_vec_sweep.sv
// Exhaustive {b,a} sweep driving a golden and a revised netlist; compares y buses, counts mismatches,
// latches the first failing vector. Optional ECO_SWEEP_STOP_ON_FAIL_EN ends the sweep on the first mismatch.
module eco_vec_sweep #(
  parameter int W      = 4,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic [W-1:0]   a_o,
  output logic [W-1:0]   b_o,
  input  logic [W-1:0]   y_gold,
  input  logic [W-1:0]   y_rev,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W:0]   err_cnt,
  output logic           first_valid,
  output logic [W-1:0]   first_a,
  output logic [W-1:0]   first_b,
  output logic [W-1:0]   first_diff
);
  localparam int IW = 2*W;
  localparam int EW = 2*W+1;
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE+1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [EW-1:0]   err_q, err_d;
  logic            pass_q, pass_d;
  logic            fv_q, fv_d;
  logic [W-1:0]    fa_q, fa_d, fb_q, fb_d, fd_q, fd_d;
  logic            sample, mism, stop;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pass_d  = pass_q;
    fv_d    = fv_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    fd_d    = fd_q;
    sample  = (state_q == S_RUN) && (cnt_q == CW'(SETTLE));
    mism    = sample && (y_gold != y_rev);
    stop    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          fv_d    = 1'b0;
          fa_d    = '0;
          fb_d    = '0;
          fd_d    = '0;
        end
      end
      S_RUN: begin
        if (!sample) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (mism) begin
            err_d = err_q + EW'(1);
            if (!fv_q) begin
              fv_d = 1'b1;
              fa_d = idx_q[W-1:0];
              fb_d = idx_q[IW-1:W];
              fd_d = y_gold ^ y_rev;
            end
          end
`ifdef ECO_SWEEP_STOP_ON_FAIL_EN
          // Hold the failing vector on the operand buses for inspection.
          stop  = (&idx_q) || mism;
          idx_d = mism ? idx_q : idx_q + 1'b1;
`else
          stop  = &idx_q;
          idx_d = idx_q + 1'b1;
`endif
          if (stop) begin
            state_d = S_DONE;
            pass_d  = (err_d == '0);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      fv_q    <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
      fd_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      fv_q    <= fv_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fd_q    <= fd_d;
    end
  end

  assign a_o         = idx_q[W-1:0];
  assign b_o         = idx_q[IW-1:W];
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign pass        = pass_q;
  assign err_cnt     = err_q;
  assign first_valid = fv_q;
  assign first_a     = fa_q;
  assign first_b     = fb_q;
  assign first_diff  = fd_q;
endmodule

// File: tb/tb_eco_vec_sweep.sv
// Directed bench for eco_vec_sweep: golden netlist is a 4-bit adder, revised netlist is the adder with an injectable fault.
module tb_eco_vec_sweep;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_o, b_o, y_gold, y_rev;
  logic         busy, done, pass, first_valid;
  logic [2*W:0] err_cnt;
  logic [W-1:0] first_a, first_b, first_diff;
  int           mode = 0;
  int           n_chk = 0;
  int           n_fail = 0;
  int           cyc;

  eco_vec_sweep #(.W(W), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_o(a_o), .b_o(b_o),
    .y_gold(y_gold), .y_rev(y_rev), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_valid(first_valid), .first_a(first_a),
    .first_b(first_b), .first_diff(first_diff)
  );

  always #5 clk = ~clk;

  assign y_gold = a_o + b_o;
  assign y_rev  = (mode == 1) ? (y_gold ^ 4'b0001) :
                  (mode == 2 && a_o == 4'd5 && b_o == 4'd3) ? (y_gold ^ 4'b0100) : y_gold;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Start on the next edge, hold start for `hold` cycles, count busy cycles until done (bounded).
  task automatic run_sweep(input int hold, output int n);
    n = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (i + 1 >= hold) start = 1'b0;
      if (!busy) break;
      n++;
    end
    start = 1'b0;
    if (busy) chk("sweep_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_ab", 32'({b_o, a_o}), 0);
    chk("rst_fv", 32'(first_valid), 0);
    rst_n = 1'b1;

    // 1: identical netlists
    mode = 0;
    run_sweep(1, cyc);
    chk("t1_cycles", cyc, 512);
    chk("t1_done", 32'(done), 1);
    chk("t1_pass", 32'(pass), 1);
    chk("t1_err", 32'(err_cnt), 0);
    chk("t1_fv", 32'(first_valid), 0);
    chk("t1_ab_wrap", 32'({b_o, a_o}), 0);
    repeat (3) @(negedge clk);
    chk("t1_done_held", 32'(done), 1);

`ifdef ECO_SWEEP_STOP_ON_FAIL_EN
    // 2: every vector fails; stop on the very first
    mode = 1;
    run_sweep(1, cyc);
    chk("t2_cycles", cyc, 2);
    chk("t2_err", 32'(err_cnt), 1);
    chk("t2_first_diff", 32'(first_diff), 1);
    chk("t2_pass", 32'(pass), 0);
    // 6: single fault at a=5,b=3 -> stop after 54 vectors
    mode = 2;
    run_sweep(1, cyc);
    chk("t6_cycles", cyc, 108);
    chk("t6_a_hold", 32'(a_o), 5);
    chk("t6_b_hold", 32'(b_o), 3);
    chk("t6_err", 32'(err_cnt), 1);
    chk("t6_pass", 32'(pass), 0);
`else
    // 2: every vector fails
    mode = 1;
    run_sweep(1, cyc);
    chk("t2_cycles", cyc, 512);
    chk("t2_err", 32'(err_cnt), 256);
    chk("t2_first_a", 32'(first_a), 0);
    chk("t2_first_b", 32'(first_b), 0);
    chk("t2_first_diff", 32'(first_diff), 1);
    chk("t2_pass", 32'(pass), 0);
    // 3: single fault at a=5,b=3
    mode = 2;
    run_sweep(1, cyc);
    chk("t3_cycles", cyc, 512);
    chk("t3_err", 32'(err_cnt), 1);
    chk("t3_first_a", 32'(first_a), 5);
    chk("t3_first_b", 32'(first_b), 3);
    chk("t3_first_diff", 32'(first_diff), 4);
    chk("t3_fv", 32'(first_valid), 1);
    chk("t3_pass", 32'(pass), 0);
`endif

    // 4: start held through part of RUN must not restart; next sweep clears results
    mode = 2;
    run_sweep(60, cyc);
`ifdef ECO_SWEEP_STOP_ON_FAIL_EN
    chk("t4_cycles_held", cyc, 108);
`else
    chk("t4_cycles_held", cyc, 512);
`endif
    chk("t4_err1", 32'(err_cnt), 1);
    mode = 0;
    run_sweep(1, cyc);
    chk("t4_cycles2", cyc, 512);
    chk("t4_err_cleared", 32'(err_cnt), 0);
    chk("t4_fv_cleared", 32'(first_valid), 0);
    chk("t4_pass", 32'(pass), 1);

    // 5: reset mid-sweep, then a fresh full sweep
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    chk("t5_busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_err", 32'(err_cnt), 0);
    chk("t5_rst_ab", 32'({b_o, a_o}), 0);
    chk("t5_rst_fv", 32'(first_valid), 0);
    chk("t5_rst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_start_ab", 32'({b_o, a_o}), 0);
    chk("t5_start_busy", 32'(busy), 1);
    chk("t5_start_done", 32'(done), 0);
    cyc = 1;
    for (int i = 0; i < 2000 && busy; i++) begin
      @(negedge clk);
      if (busy) cyc++;
    end
    chk("t5_cycles", cyc, 512);
    chk("t5_pass", 32'(pass), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
